// File: rtl/board_move_executor_if.sv
// Command/response channel, status outputs and square-read port between the
// search engine (master) and the board move executor (slave).
interface board_move_executor_if #(
  parameter int SW = 4
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [11:0]        cmd_move;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_err;
  logic               white_to_move;
  logic signed [15:0] material;
  logic [SW-1:0]      stack_cnt;
  logic [5:0]         sq_addr;
  logic [3:0]         sq_piece;

  modport master (
    output cmd_valid, cmd_op, cmd_move, resp_ready, sq_addr,
    input  cmd_ready, resp_valid, resp_err, white_to_move, material, stack_cnt, sq_piece
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_move, resp_ready, sq_addr,
    output cmd_ready, resp_valid, resp_err, white_to_move, material, stack_cnt, sq_piece
  );
endinterface

// File: rtl/board_move_executor.sv
// Executes MAKE / UNDO / INIT commands on the on-chip board, keeping an undo
// stack, the side to move and an incremental white-minus-black material score.
module board_move_executor #(
  parameter int STACK_DEPTH = 8,
  parameter int SW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  board_move_executor_if.slave bus_if
);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [1:0] OP_MAKE = 2'b01;
  localparam logic [1:0] OP_UNDO = 2'b10;
  localparam logic [1:0] OP_INIT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t             state_q;
  logic [1:0]         op_q;
  logic [11:0]        move_q;
  logic               cmd_ready_q;
  logic               resp_valid_q;
  logic               resp_err_q;
  logic               wtm_q;
  logic signed [15:0] material_q;
  logic [SW-1:0]      stack_cnt_q;
  logic [3:0]         board_q [64];
  logic [19:0]        stack_mem [STACK_DEPTH];

  function automatic logic [3:0] start_piece(input logic [5:0] sq);
    logic [2:0] t;
    case (sq[2:0])
      3'd0, 3'd7: t = 3'd4;
      3'd1, 3'd6: t = 3'd2;
      3'd2, 3'd5: t = 3'd3;
      3'd3:       t = 3'd5;
      default:    t = 3'd6;
    endcase
    case (sq[5:3])
      3'd0:    return {1'b0, t};
      3'd1:    return 4'd1;
      3'd6:    return 4'd9;
      3'd7:    return {1'b1, t};
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic signed [15:0] piece_value(input logic [2:0] t);
    case (t)
      3'd1:    return 16'sd100;
      3'd2:    return 16'sd320;
      3'd3:    return 16'sd330;
      3'd4:    return 16'sd500;
      3'd5:    return 16'sd900;
      default: return 16'sd0;
    endcase
  endfunction

  logic [5:0]         from_w, to_w, u_from_w, u_to_w;
  logic [3:0]         moved_w, capt_w, u_moved_w, u_capt_w;
  logic [AW-1:0]      top_idx_w;
  logic [19:0]        top_w;
  logic               make_err_w, undo_err_w, do_make_w;
  logic signed [15:0] material_d;
  logic               err_d;

  assign from_w    = move_q[11:6];
  assign to_w      = move_q[5:0];
  assign moved_w   = board_q[from_w];
  assign capt_w    = board_q[to_w];
  assign top_idx_w = AW'(stack_cnt_q - 1'b1);
  assign top_w     = stack_mem[top_idx_w];
  assign u_from_w  = top_w[19:14];
  assign u_to_w    = top_w[13:8];
  assign u_moved_w = top_w[7:4];
  assign u_capt_w  = top_w[3:0];

  // Moving piece's colour bit (1 = black) must be the opposite of white_to_move.
  assign make_err_w = (stack_cnt_q == SW'(STACK_DEPTH)) || (moved_w == 4'd0) ||
                      (from_w == to_w) || (moved_w[3] == wtm_q);
  assign undo_err_w = (stack_cnt_q == '0);
  assign do_make_w  = (state_q == S_EXEC) && (op_q == OP_MAKE) && !make_err_w;

  always_comb begin
    material_d = material_q;
    err_d      = 1'b0;
    case (op_q)
      OP_MAKE: begin
        if (make_err_w)  err_d = 1'b1;
        else if (wtm_q)  material_d = material_q + piece_value(capt_w[2:0]);
        else             material_d = material_q - piece_value(capt_w[2:0]);
      end
      OP_UNDO: begin
        if (undo_err_w)        err_d = 1'b1;
        else if (u_moved_w[3]) material_d = material_q + piece_value(u_capt_w[2:0]);
        else                   material_d = material_q - piece_value(u_capt_w[2:0]);
      end
      OP_INIT: material_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= 2'b00;
      move_q       <= '0;
      cmd_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      wtm_q        <= 1'b1;
      material_q   <= '0;
      stack_cnt_q  <= '0;
      for (int i = 0; i < 64; i++) board_q[i] <= start_piece(6'(i));
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_if.cmd_valid && cmd_ready_q) begin
            op_q        <= bus_if.cmd_op;
            move_q      <= bus_if.cmd_move;
            cmd_ready_q <= 1'b0;
            state_q     <= S_EXEC;
          end
        end
        S_EXEC: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= err_d;
          material_q   <= material_d;
          case (op_q)
            OP_MAKE: if (!make_err_w) begin
              board_q[to_w]   <= moved_w;
              board_q[from_w] <= 4'd0;
              stack_cnt_q     <= stack_cnt_q + 1'b1;
              wtm_q           <= ~wtm_q;
            end
            OP_UNDO: if (!undo_err_w) begin
              board_q[u_to_w]   <= u_capt_w;
              board_q[u_from_w] <= u_moved_w;
              stack_cnt_q       <= stack_cnt_q - 1'b1;
              wtm_q             <= ~wtm_q;
            end
            OP_INIT: begin
              for (int i = 0; i < 64; i++) board_q[i] <= start_piece(6'(i));
              stack_cnt_q <= '0;
              wtm_q       <= 1'b1;
            end
            default: ;
          endcase
        end
        S_RESP: begin
          if (bus_if.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            cmd_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stack contents need no reset: the pointer alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_make_w) stack_mem[AW'(stack_cnt_q)] <= {from_w, to_w, moved_w, capt_w};
  end

  assign bus_if.cmd_ready     = cmd_ready_q;
  assign bus_if.resp_valid    = resp_valid_q;
  assign bus_if.resp_err      = resp_err_q;
  assign bus_if.white_to_move = wtm_q;
  assign bus_if.material      = material_q;
  assign bus_if.stack_cnt     = stack_cnt_q;
  assign bus_if.sq_piece      = board_q[bus_if.sq_addr];
endmodule

// File: tb/tb_board_move_executor.sv
// Scoreboard bench for board_move_executor: a chess-rule reference model
// predicts each response, which is popped and compared when the DUT answers.
`timescale 1ns/1ps
module tb_board_move_executor;
  localparam logic [1:0] OP_NOP = 2'b00, OP_MAKE = 2'b01, OP_UNDO = 2'b10, OP_INIT = 2'b11;

  typedef struct packed {
    logic               err;
    logic               wtm;
    logic signed [15:0] mat;
    logic [3:0]         cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  board_move_executor_if #(.SW(4)) bus();
  board_move_executor #(.STACK_DEPTH(8), .SW(4)) dut (.clk(clk), .rst_n(rst_n), .bus_if(bus));

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  logic [3:0]         mb [64];
  logic               mwtm;
  logic signed [15:0] mmat;
  logic [19:0]        ms[$];
  logic [3:0]         snap [64];

  function automatic int val(input logic [3:0] p);
    case (p[2:0])
      3'd1: return 100;
      3'd2: return 320;
      3'd3: return 330;
      3'd4: return 500;
      3'd5: return 900;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    int back [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    for (int s = 0; s < 64; s++) mb[s] = 4'd0;
    for (int f = 0; f < 8; f++) begin
      mb[f]      = 4'(back[f]);
      mb[8 + f]  = 4'd1;
      mb[48 + f] = 4'd9;
      mb[56 + f] = 4'(8 + back[f]);
    end
    mwtm = 1'b1;
    mmat = '0;
    ms.delete();
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [11:0] mv, output exp_t e);
    logic [5:0] f, t;
    logic [3:0] mp, cp;
    logic [19:0] ent;
    f = mv[11:6];
    t = mv[5:0];
    e.err = 1'b0;
    case (op)
      OP_MAKE: begin
        mp = mb[f];
        cp = mb[t];
        if (ms.size() >= 8 || mp == 4'd0 || f == t || mp[3] != ~mwtm) e.err = 1'b1;
        else begin
          ms.push_back({f, t, mp, cp});
          mb[t] = mp;
          mb[f] = 4'd0;
          if (mwtm) mmat = mmat + 16'(val(cp));
          else      mmat = mmat - 16'(val(cp));
          mwtm = ~mwtm;
        end
      end
      OP_UNDO: begin
        if (ms.size() == 0) e.err = 1'b1;
        else begin
          ent = ms.pop_back();
          f = ent[19:14]; t = ent[13:8]; mp = ent[7:4]; cp = ent[3:0];
          mb[t] = cp;
          mb[f] = mp;
          mwtm = ~mwtm;
          if (mwtm) mmat = mmat - 16'(val(cp));
          else      mmat = mmat + 16'(val(cp));
        end
      end
      OP_INIT: model_reset();
      default: ;
    endcase
    e.wtm = mwtm;
    e.mat = mmat;
    e.cnt = 4'(ms.size());
  endtask

  task automatic read_sq(input int sq, output logic [3:0] p);
    bus.sq_addr = 6'(sq);
    #1;
    p = bus.sq_piece;
  endtask

  // Drive one command, hold the response for 'hold' cycles, then compare against the scoreboard.
  task automatic do_cmd(input logic [1:0] op, input logic [11:0] mv, input int hold, input string tag);
    exp_t e, q;
    int n, lat, bad, first_sq;
    logic [3:0] p, first_got;
    model_apply(op, mv, e);
    exp_q.push_back(e);
    bus.cmd_op = op;
    bus.cmd_move = mv;
    bus.cmd_valid = 1'b1;
    bus.resp_ready = 1'b0;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL %s latency: resp_valid on edge %0d after accept (incl.), required 2", tag, lat);
    end
    if (bus.resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: resp_valid never rose", tag);
      exp_q.delete();
      return;
    end
    q = exp_q.pop_front();
    checks++;
    if (bus.resp_err !== q.err) begin
      errors++; $display("FAIL %s resp_err: got %0b expected %0b", tag, bus.resp_err, q.err);
    end
    checks++;
    if (bus.white_to_move !== q.wtm) begin
      errors++; $display("FAIL %s white_to_move: got %0b expected %0b", tag, bus.white_to_move, q.wtm);
    end
    checks++;
    if (bus.material !== q.mat) begin
      errors++; $display("FAIL %s material: got %0d expected %0d", tag, bus.material, q.mat);
    end
    checks++;
    if (bus.stack_cnt !== q.cnt) begin
      errors++; $display("FAIL %s stack_cnt: got %0d expected %0d", tag, bus.stack_cnt, q.cnt);
    end
    bad = 0; first_sq = 0; first_got = 4'd0;
    for (int s = 0; s < 64; s++) begin
      read_sq(s, p);
      if (p !== mb[s]) begin
        if (bad == 0) begin first_sq = s; first_got = p; end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s board: %0d squares differ, sq%0d got %0d expected %0d", tag, bad, first_sq, first_got, mb[first_sq]);
    end
    @(posedge clk); #1;
    for (int i = 0; i < hold; i++) begin
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_err !== q.err || bus.cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: valid=%0b err=%0b ready=%0b expected 1 %0b 0", tag, i, bus.resp_valid, bus.resp_err, bus.cmd_ready, q.err);
      end
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: valid=%0b ready=%0b expected 0 1", tag, bus.resp_valid, bus.cmd_ready);
    end
    $display("txn %s op=%0d from=%0d to=%0d err=%0b wtm=%0b mat=%0d cnt=%0d", tag, op, mv[11:6], mv[5:0], q.err, q.wtm, q.mat, q.cnt);
  endtask

  task automatic test_reset();
    logic [3:0] p;
    read_sq(4, p);
    checks++; if (p !== 4'd6)  begin errors++; $display("FAIL reset sq4: got %0d expected 6", p); end
    read_sq(60, p);
    checks++; if (p !== 4'd14) begin errors++; $display("FAIL reset sq60: got %0d expected 14", p); end
    read_sq(12, p);
    checks++; if (p !== 4'd1)  begin errors++; $display("FAIL reset sq12: got %0d expected 1", p); end
    checks++; if (bus.white_to_move !== 1'b1) begin errors++; $display("FAIL reset wtm: got %0b expected 1", bus.white_to_move); end
    checks++; if (bus.material !== 16'sd0) begin errors++; $display("FAIL reset material: got %0d expected 0", bus.material); end
    checks++; if (bus.stack_cnt !== 4'd0) begin errors++; $display("FAIL reset stack_cnt: got %0d expected 0", bus.stack_cnt); end
    checks++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset handshake: valid=%0b err=%0b ready=%0b expected 0 0 1", bus.resp_valid, bus.resp_err, bus.cmd_ready);
    end
    $display("txn reset checked");
  endtask

  task automatic test_make_e2e4();
    logic [3:0] p;
    do_cmd(OP_MAKE, {6'd12, 6'd28}, 0, "e2e4");
    read_sq(28, p);
    checks++; if (p !== 4'd1) begin errors++; $display("FAIL e2e4 sq28: got %0d expected 1", p); end
    read_sq(12, p);
    checks++; if (p !== 4'd0) begin errors++; $display("FAIL e2e4 sq12: got %0d expected 0", p); end
  endtask

  task automatic test_capture_undo();
    logic [3:0] p;
    do_cmd(OP_INIT, 12'd0, 0, "init");
    do_cmd(OP_MAKE, {6'd3, 6'd59}, 0, "QxQ");
    checks++; if (bus.material !== 16'sd900) begin errors++; $display("FAIL QxQ material: got %0d expected 900", bus.material); end
    do_cmd(OP_UNDO, 12'd0, 0, "undoQxQ");
    read_sq(59, p);
    checks++; if (p !== 4'd13) begin errors++; $display("FAIL undo sq59: got %0d expected 13", p); end
    read_sq(3, p);
    checks++; if (p !== 4'd5) begin errors++; $display("FAIL undo sq3: got %0d expected 5", p); end
    checks++; if (bus.material !== 16'sd0 || bus.white_to_move !== 1'b1) begin
      errors++; $display("FAIL undo state: material=%0d wtm=%0b expected 0 1", bus.material, bus.white_to_move);
    end
  endtask

  task automatic test_errors();
    do_cmd(OP_INIT, 12'd0, 0, "init");
    do_cmd(OP_UNDO, 12'd0, 0, "undo_empty");
    do_cmd(OP_MAKE, {6'd20, 6'd28}, 0, "from_empty");
    do_cmd(OP_MAKE, {6'd52, 6'd44}, 0, "wrong_color");
    do_cmd(OP_MAKE, {6'd12, 6'd12}, 0, "from_eq_to");
    do_cmd(OP_NOP, 12'd0, 0, "nop");
    for (int i = 0; i < 4; i++) begin
      do_cmd(OP_MAKE, {6'(8 + i), 6'(16 + i)}, 0, "fill_w");
      do_cmd(OP_MAKE, {6'(48 + i), 6'(40 + i)}, 0, "fill_b");
    end
    do_cmd(OP_MAKE, {6'd12, 6'd20}, 0, "stack_full");
  endtask

  task automatic test_hold_reset();
    logic [3:0] p;
    int n;
    do_cmd(OP_INIT, 12'd0, 0, "init");
    do_cmd(OP_MAKE, {6'd12, 6'd28}, 0, "e2e4");
    do_cmd(OP_MAKE, {6'd52, 6'd36}, 5, "e7e5_hold");
    bus.cmd_op = OP_MAKE;
    bus.cmd_move = {6'd11, 6'd27};
    bus.cmd_valid = 1'b1;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    checks++; if (bus.cmd_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++; $display("FAIL exec_state: ready=%0b valid=%0b expected 0 0", bus.cmd_ready, bus.resp_valid);
    end
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    read_sq(11, p);
    checks++; if (p !== 4'd1) begin errors++; $display("FAIL midreset sq11: got %0d expected 1", p); end
    read_sq(28, p);
    checks++; if (p !== 4'd0) begin errors++; $display("FAIL midreset sq28: got %0d expected 0", p); end
    read_sq(52, p);
    checks++; if (p !== 4'd9) begin errors++; $display("FAIL midreset sq52: got %0d expected 9", p); end
    checks++; if (bus.stack_cnt !== 4'd0 || bus.white_to_move !== 1'b1 || bus.material !== 16'sd0) begin
      errors++; $display("FAIL midreset state: cnt=%0d wtm=%0b mat=%0d expected 0 1 0", bus.stack_cnt, bus.white_to_move, bus.material);
    end
    checks++; if (bus.resp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL midreset handshake: valid=%0b ready=%0b expected 0 1", bus.resp_valid, bus.cmd_ready);
    end
    $display("txn midexec_reset checked");
  endtask

  task automatic test_random();
    int f, t, bad, tries;
    logic [3:0] p;
    do_cmd(OP_INIT, 12'd0, 0, "init");
    for (int s = 0; s < 64; s++) snap[s] = mb[s];
    for (int i = 0; i < 5; i++) begin
      f = $urandom_range(0, 63);
      tries = 0;
      while ((mb[f] == 4'd0 || mb[f][3] != ~mwtm) && tries < 500) begin f = $urandom_range(0, 63); tries++; end
      t = $urandom_range(0, 63);
      while (t == f) t = $urandom_range(0, 63);
      do_cmd(OP_MAKE, {6'(f), 6'(t)}, 0, "rand_make");
    end
    for (int i = 0; i < 5; i++) do_cmd(OP_UNDO, 12'd0, 0, "rand_undo");
    bad = 0;
    for (int s = 0; s < 64; s++) begin
      read_sq(s, p);
      if (p !== snap[s]) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL random snapshot: %0d squares differ, required 0", bad); end
    checks++; if (bus.material !== 16'sd0 || bus.white_to_move !== 1'b1 || bus.stack_cnt !== 4'd0) begin
      errors++; $display("FAIL random state: mat=%0d wtm=%0b cnt=%0d expected 0 1 0", bus.material, bus.white_to_move, bus.stack_cnt);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = OP_NOP;
    bus.cmd_move = 12'd0;
    bus.resp_ready = 1'b0;
    bus.sq_addr = 6'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_make_e2e4();
    test_capture_undo();
    test_errors();
    test_hold_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
